// File: rtl/pkt_tx_if.sv
// Handshake bundle between the packet transmitter and its neighbours.
// The master modport is the transmitter's view of the bundle. The slave modport is the environment's view.
interface pkt_tx_if;
  logic [600:0] s_axis_pkt_TDATA;
  logic         s_axis_pkt_TVALID;
  logic         s_axis_pkt_TREADY;

  logic [31:0]  m_axis_tx_meta_TDATA;
  logic         m_axis_tx_meta_TVALID;
  logic         m_axis_tx_meta_TREADY;

  logic [63:0]  s_axis_tx_status_TDATA;
  logic         s_axis_tx_status_TVALID;
  logic         s_axis_tx_status_TREADY;

  logic [512:0] m_axis_tx_data_TDATA;
  logic [63:0]  m_axis_tx_data_TKEEP;
  logic         m_axis_tx_data_TVALID;
  logic         m_axis_tx_data_TREADY;

  modport master (
    input  s_axis_pkt_TDATA, s_axis_pkt_TVALID,
    output s_axis_pkt_TREADY,
    output m_axis_tx_meta_TDATA, m_axis_tx_meta_TVALID,
    input  m_axis_tx_meta_TREADY,
    input  s_axis_tx_status_TDATA, s_axis_tx_status_TVALID,
    output s_axis_tx_status_TREADY,
    output m_axis_tx_data_TDATA, m_axis_tx_data_TKEEP, m_axis_tx_data_TVALID,
    input  m_axis_tx_data_TREADY
  );

  modport slave (
    output s_axis_pkt_TDATA, s_axis_pkt_TVALID,
    input  s_axis_pkt_TREADY,
    input  m_axis_tx_meta_TDATA, m_axis_tx_meta_TVALID,
    output m_axis_tx_meta_TREADY,
    output s_axis_tx_status_TDATA, s_axis_tx_status_TVALID,
    input  s_axis_tx_status_TREADY,
    input  m_axis_tx_data_TDATA, m_axis_tx_data_TKEEP, m_axis_tx_data_TVALID,
    output m_axis_tx_data_TREADY
  );
endinterface

// File: rtl/pkt_transmitter.sv
// TCP TX packet transmitter: meta request, status wait with retry/back-off, then payload pass-through.
// Optional statistics counters are enabled by defining PKT_TX_STATS_EN.
module pkt_transmitter #(
  parameter int MAX_RETRY = 3,
  parameter int RETRY_GAP = 16,
  parameter int MAX_LEN   = 2048
) (
  input  logic        clk,
  input  logic        rst,
  pkt_tx_if.master    bus
`ifdef PKT_TX_STATS_EN
  ,
  output logic [31:0] stat_sent,
  output logic [31:0] stat_dropped,
  output logic [31:0] stat_retries
`endif
);

  typedef enum logic [2:0] {IDLE, META, STATUS, BACKOFF, DATA, DROP} state_e;

  localparam logic [3:0]  MaxRetry = 4'(MAX_RETRY);
  localparam logic [7:0]  GapLast  = 8'(RETRY_GAP - 1);
  localparam logic [16:0] MaxLen   = 17'(MAX_LEN);

  state_e      state_q;
  logic [15:0] session_q;
  logic [15:0] rem_q;
  logic [31:0] meta_q;
  logic        meta_valid_q;
  logic        status_ready_q;
  logic [3:0]  retry_q;
  logic [7:0]  gap_q;

  logic [15:0] head_session;
  logic [15:0] head_len;
  logic        in_last;
  logic        len_bad;
  logic        status_ok;
  logic        status_fire;
  logic        data_fire;
  logic [3:0]  retry_d;
  logic [15:0] rem_d;
  logic [63:0] keep;

  assign head_session = bus.s_axis_pkt_TDATA[528:513];
  assign head_len     = bus.s_axis_pkt_TDATA[544:529];
  assign in_last      = bus.s_axis_pkt_TDATA[512];
  assign len_bad      = (head_len == 16'd0) || ({1'b0, head_len} > MaxLen);

  // A status only counts as success if it is error-free and belongs to our session.
  assign status_ok   = (bus.s_axis_tx_status_TDATA[63:62] == 2'b00) &&
                       (bus.s_axis_tx_status_TDATA[15:0] == session_q);
  assign status_fire = status_ready_q && bus.s_axis_tx_status_TVALID;
  assign data_fire   = (state_q == DATA) && bus.s_axis_pkt_TVALID && bus.m_axis_tx_data_TREADY;
  assign retry_d     = retry_q + 4'd1;
  assign rem_d       = (rem_q >= 16'd64) ? rem_q - 16'd64 : 16'd0;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    keep = '1;
    if (rem_q < 16'd64) keep = (64'd1 << rem_q[5:0]) - 64'd1;
  end

  assign bus.s_axis_pkt_TREADY       = ((state_q == DATA) && bus.m_axis_tx_data_TREADY) ||
                                       (state_q == DROP);
  assign bus.m_axis_tx_meta_TDATA    = meta_q;
  assign bus.m_axis_tx_meta_TVALID   = meta_valid_q;
  assign bus.s_axis_tx_status_TREADY = status_ready_q;
  assign bus.m_axis_tx_data_TDATA    = bus.s_axis_pkt_TDATA[512:0];
  assign bus.m_axis_tx_data_TKEEP    = keep;
  assign bus.m_axis_tx_data_TVALID   = (state_q == DATA) && bus.s_axis_pkt_TVALID;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      session_q      <= '0;
      rem_q          <= '0;
      meta_q         <= '0;
      meta_valid_q   <= 1'b0;
      status_ready_q <= 1'b0;
      retry_q        <= '0;
      gap_q          <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // The head beat is only inspected here; DATA or DROP consumes it.
          if (bus.s_axis_pkt_TVALID) begin
            session_q <= head_session;
            if (len_bad) begin
              state_q <= DROP;
            end else begin
              meta_q       <= {head_len, head_session};
              rem_q        <= head_len;
              retry_q      <= '0;
              meta_valid_q <= 1'b1;
              state_q      <= META;
            end
          end
        end
        META: begin
          if (bus.m_axis_tx_meta_TREADY) begin
            meta_valid_q   <= 1'b0;
            status_ready_q <= 1'b1;
            state_q        <= STATUS;
          end
        end
        STATUS: begin
          if (bus.s_axis_tx_status_TVALID) begin
            status_ready_q <= 1'b0;
            if (status_ok) begin
              state_q <= DATA;
            end else begin
              retry_q <= retry_d;
              if (retry_d == MaxRetry) begin
                state_q <= DROP;
              end else begin
                gap_q   <= '0;
                state_q <= BACKOFF;
              end
            end
          end
        end
        BACKOFF: begin
          if (gap_q == GapLast) begin
            meta_valid_q <= 1'b1;
            state_q      <= META;
          end else begin
            gap_q <= gap_q + 8'd1;
          end
        end
        DATA: begin
          if (data_fire) begin
            rem_q <= rem_d;
            if (in_last) state_q <= IDLE;
          end
        end
        DROP: begin
          if (bus.s_axis_pkt_TVALID && in_last) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef PKT_TX_STATS_EN
  logic enter_drop;
  assign enter_drop = ((state_q == IDLE) && bus.s_axis_pkt_TVALID && len_bad) ||
                      (status_fire && !status_ok && (retry_d == MaxRetry));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_sent    <= '0;
      stat_dropped <= '0;
      stat_retries <= '0;
    end else begin
      if (data_fire && in_last)       stat_sent    <= stat_sent + 32'd1;
      if (enter_drop)                 stat_dropped <= stat_dropped + 32'd1;
      if (status_fire && !status_ok)  stat_retries <= stat_retries + 32'd1;
    end
  end
`endif

  logic unused_bits;
  assign unused_bits = ^{bus.s_axis_pkt_TDATA[600:545], bus.s_axis_tx_status_TDATA[61:16]};

endmodule

// File: tb/tb_pkt_transmitter.sv
// Directed, table-driven bench for pkt_transmitter, plus hand-written retry, back-pressure and reset sequences.
module tb_pkt_transmitter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pkt_tx_if bus();

`ifdef PKT_TX_STATS_EN
  logic [31:0] stat_sent, stat_dropped, stat_retries;
`endif

  pkt_transmitter #(.MAX_RETRY(3), .RETRY_GAP(16), .MAX_LEN(2048)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef PKT_TX_STATS_EN
    ,
    .stat_sent(stat_sent),
    .stat_dropped(stat_dropped),
    .stat_retries(stat_retries)
`endif
  );

  typedef struct packed {
    logic [87:0]  meta;
    logic         last;
    logic [511:0] data;
  } beat_t;

  typedef struct packed {
    logic [512:0] tdata;
    logic [63:0]  tkeep;
  } out_t;

  typedef struct {
    logic [15:0] sess;
    logic [15:0] len;
    int          beats;
    bit          sent;
    logic [31:0] exp_meta;
    logic [63:0] last_keep;
  } vec_t;

  beat_t       src_q[$];
  beat_t       exp_q[$];
  logic [63:0] st_q[$];
  logic [31:0] meta_rec[$];
  int          meta_cyc[$];
  int          st_cyc[$];
  out_t        data_rec[$];
  int          cyc = 0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [512:0] act, input logic [512:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_keep(input int len, input int b);
    logic [63:0] k;
    int rem;
    rem = len - 64 * b;
    if (rem < 0) rem = 0;
    for (int i = 0; i < 64; i++) k[i] = (i < rem);
    return k;
  endfunction

  task automatic push_pkt(input logic [15:0] sess, input logic [15:0] len, input int beats);
    beat_t bt;
    for (int b = 0; b < beats; b++) begin
      bt.meta = {56'hA55AC33C0FF096, len, sess};
      bt.last = (b == beats - 1);
      for (int w = 0; w < 16; w++) bt.data[w*32 +: 32] = $urandom;
      src_q.push_back(bt);
      exp_q.push_back(bt);
    end
  endtask

  function automatic logic [63:0] status_word(input logic [1:0] err, input logic [15:0] len,
                                              input logic [15:0] sess);
    return {err, 30'h0, len, sess};
  endfunction

  task automatic clear_all();
    src_q.delete(); exp_q.delete(); st_q.delete();
    meta_rec.delete(); meta_cyc.delete(); st_cyc.delete(); data_rec.delete();
  endtask

  // Drives inputs at the falling edge, then records which handshakes complete at the next rising edge.
  task automatic run(input int budget, input int stop_beats, input bit bp);
    int idle = 0;
    bit tog = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      bus.s_axis_pkt_TVALID       = (src_q.size() > 0);
      if (src_q.size() > 0) bus.s_axis_pkt_TDATA = src_q[0];
      bus.s_axis_tx_status_TVALID = (st_q.size() > 0);
      if (st_q.size() > 0) bus.s_axis_tx_status_TDATA = st_q[0];
      bus.m_axis_tx_meta_TREADY   = 1'b1;
      bus.m_axis_tx_data_TREADY   = bp ? tog : 1'b1;
      tog = ~tog;
      #1;
      if (bus.s_axis_pkt_TVALID && bus.s_axis_pkt_TREADY) void'(src_q.pop_front());
      if (bus.m_axis_tx_meta_TVALID && bus.m_axis_tx_meta_TREADY) begin
        meta_rec.push_back(bus.m_axis_tx_meta_TDATA);
        meta_cyc.push_back(cyc);
      end
      if (bus.s_axis_tx_status_TVALID && bus.s_axis_tx_status_TREADY) begin
        void'(st_q.pop_front());
        st_cyc.push_back(cyc);
      end
      if (bus.m_axis_tx_data_TVALID && bus.m_axis_tx_data_TREADY)
        data_rec.push_back({bus.m_axis_tx_data_TDATA, bus.m_axis_tx_data_TKEEP});
      cyc++;
      if (stop_beats > 0 && data_rec.size() >= stop_beats) return;
      if (stop_beats == 0 && src_q.size() == 0) begin
        idle++;
        if (idle > 4) return;
      end
    end
    n_checks++;
    n_errors++;
    $display("FAIL run budget: got %0d cycles without completion, required completion", budget);
  endtask

  task automatic check_beats(input string tag, input int len);
    check({tag, " beat count"}, data_rec.size(), exp_q.size());
    if (data_rec.size() == exp_q.size()) begin
      for (int b = 0; b < exp_q.size(); b++) begin
        check($sformatf("%s beat %0d data", tag, b), data_rec[b].tdata, {exp_q[b].last, exp_q[b].data});
        check($sformatf("%s beat %0d keep", tag, b), data_rec[b].tkeep, model_keep(len, b));
      end
    end
  endtask

  vec_t vecs[8];

  initial begin
    int exp_sent;
    int exp_drop;
`ifdef PKT_TX_STATS_EN
    logic [31:0] base_sent, base_drop, base_retry;
`endif
    vecs[0] = '{16'h0005, 16'd100,  2,  1'b1, 32'h0064_0005, 64'h0000_000F_FFFF_FFFF};
    vecs[1] = '{16'h1234, 16'd64,   1,  1'b1, 32'h0040_1234, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[2] = '{16'h0042, 16'd0,    2,  1'b0, 32'h0,         64'h0};
    vecs[3] = '{16'h0007, 16'd1,    1,  1'b1, 32'h0001_0007, 64'h0000_0000_0000_0001};
    vecs[4] = '{16'h0099, 16'd3000, 3,  1'b0, 32'h0,         64'h0};
    vecs[5] = '{16'h00AA, 16'd2048, 32, 1'b1, 32'h0800_00AA, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[6] = '{16'h00BB, 16'd2049, 1,  1'b0, 32'h0,         64'h0};
    vecs[7] = '{16'h00CC, 16'd65,   3,  1'b1, 32'h0041_00CC, 64'h0};

    rst = 1'b1;
    bus.s_axis_pkt_TDATA        = '0;
    bus.s_axis_pkt_TVALID       = 1'b0;
    bus.s_axis_tx_status_TDATA  = '0;
    bus.s_axis_tx_status_TVALID = 1'b0;
    bus.m_axis_tx_meta_TREADY   = 1'b0;
    bus.m_axis_tx_data_TREADY   = 1'b0;
    #2;
    check("reset pkt ready",    bus.s_axis_pkt_TREADY, 0);
    check("reset meta valid",   bus.m_axis_tx_meta_TVALID, 0);
    check("reset meta data",    bus.m_axis_tx_meta_TDATA, 0);
    check("reset status ready", bus.s_axis_tx_status_TREADY, 0);
    check("reset data valid",   bus.m_axis_tx_data_TVALID, 0);
    @(negedge clk);
    rst = 1'b0;

    exp_sent = 0;
    exp_drop = 0;
    for (int v = 0; v < 8; v++) begin
      clear_all();
      push_pkt(vecs[v].sess, vecs[v].len, vecs[v].beats);
      if (vecs[v].sent) begin
        st_q.push_back(status_word(2'b00, vecs[v].len, vecs[v].sess));
        exp_sent++;
      end else begin
        exp_drop++;
      end
      run(vecs[v].beats * 4 + 100, 0, 1'b0);
      check($sformatf("vec%0d meta count", v), meta_rec.size(), vecs[v].sent ? 1 : 0);
      check($sformatf("vec%0d input consumed", v), src_q.size(), 0);
      if (vecs[v].sent) begin
        check($sformatf("vec%0d meta", v), (meta_rec.size() > 0) ? meta_rec[0] : 32'hDEAD_BEEF,
              vecs[v].exp_meta);
        check_beats($sformatf("vec%0d", v), int'(vecs[v].len));
        check($sformatf("vec%0d last keep", v),
              (data_rec.size() > 0) ? data_rec[data_rec.size()-1].tkeep : 64'hDEAD,
              vecs[v].last_keep);
      end else begin
        check($sformatf("vec%0d no data", v), data_rec.size(), 0);
      end
    end
`ifdef PKT_TX_STATS_EN
    check("stat sent after table",    stat_sent, exp_sent);
    check("stat dropped after table", stat_dropped, exp_drop);
    check("stat retries after table", stat_retries, 0);
`endif

    // Retry once, then succeed.
    clear_all();
`ifdef PKT_TX_STATS_EN
    base_sent = stat_sent; base_retry = stat_retries;
`endif
    push_pkt(16'h0033, 16'd150, 3);
    st_q.push_back(status_word(2'b01, 16'd150, 16'h0033));
    st_q.push_back(status_word(2'b00, 16'd150, 16'h0033));
    run(400, 0, 1'b0);
    check("retry meta count", meta_rec.size(), 2);
    check("retry status count", st_cyc.size(), 2);
    if (meta_cyc.size() == 2 && st_cyc.size() == 2)
      check("retry gap at least 16", (meta_cyc[1] - st_cyc[0]) >= 16, 1);
    check("retry second meta", (meta_rec.size() > 1) ? meta_rec[1] : 32'h0, 32'h0096_0033);
    check_beats("retry", 150);
`ifdef PKT_TX_STATS_EN
    check("retry stat retries", stat_retries - base_retry, 1);
    check("retry stat sent", stat_sent - base_sent, 1);
`endif

    // Three failures (error, wrong session, error) exhaust the retries.
    clear_all();
`ifdef PKT_TX_STATS_EN
    base_drop = stat_dropped; base_retry = stat_retries;
`endif
    push_pkt(16'h0044, 16'd200, 4);
    st_q.push_back(status_word(2'b10, 16'd200, 16'h0044));
    st_q.push_back(status_word(2'b00, 16'd200, 16'h0045));
    st_q.push_back(status_word(2'b01, 16'd200, 16'h0044));
    run(400, 0, 1'b0);
    check("exhaust meta count", meta_rec.size(), 3);
    check("exhaust no data", data_rec.size(), 0);
    check("exhaust input consumed", src_q.size(), 0);
    check("exhaust statuses consumed", st_q.size(), 0);
`ifdef PKT_TX_STATS_EN
    check("exhaust stat dropped", stat_dropped - base_drop, 1);
    check("exhaust stat retries", stat_retries - base_retry, 3);
`endif

    // Output back-pressure toggling every cycle.
    clear_all();
    push_pkt(16'h0055, 16'd256, 4);
    st_q.push_back(status_word(2'b00, 16'd256, 16'h0055));
    run(200, 0, 1'b1);
    check("bp input consumed", src_q.size(), 0);
    check_beats("bp", 256);

    // Async reset in the middle of DATA.
    clear_all();
    push_pkt(16'h0066, 16'd256, 4);
    st_q.push_back(status_word(2'b00, 16'd256, 16'h0066));
    run(200, 2, 1'b0);
    @(posedge clk);
    #2;
    check("mid-packet data valid before reset", bus.m_axis_tx_data_TVALID, 1);
    rst = 1'b1;
    #1;
    check("async reset data valid",   bus.m_axis_tx_data_TVALID, 0);
    check("async reset pkt ready",    bus.s_axis_pkt_TREADY, 0);
    check("async reset meta valid",   bus.m_axis_tx_meta_TVALID, 0);
    check("async reset status ready", bus.s_axis_tx_status_TREADY, 0);
    check("async reset meta data",    bus.m_axis_tx_meta_TDATA, 0);
`ifdef PKT_TX_STATS_EN
    check("async reset stat sent",    stat_sent, 0);
    check("async reset stat dropped", stat_dropped, 0);
    check("async reset stat retries", stat_retries, 0);
`endif
    clear_all();
    bus.s_axis_pkt_TVALID       = 1'b0;
    bus.s_axis_tx_status_TVALID = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    push_pkt(16'h0077, 16'd10, 1);
    st_q.push_back(status_word(2'b00, 16'd10, 16'h0077));
    run(100, 0, 1'b0);
    check("post-reset meta", (meta_rec.size() > 0) ? meta_rec[0] : 32'h0, 32'h000A_0077);
    check("post-reset keep", (data_rec.size() > 0) ? data_rec[0].tkeep : 64'h0, 64'h3FF);
    check_beats("post-reset", 10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
